cpu_io_port: RTL and testbench

Word-wide I/O port that sits on the far side of the processor's `data_out`/`data_in` pins. It buffers words written by the CPU into a TX FIFO for the host/testbench, and buffers host-supplied words into an RX FIFO presented to the CPU. Flow is valid/ready on the host side and write-strobe/acknowledge on the CPU side. Sticky error flags record dropped writes and reads from an empty port.

---
 rtl/cpu_io_port.sv | 103 ++++++++++
 tb/tb_cpu_io_port.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cpu_io_port.sv
// rtl/cpu_io_port.sv - CPU-side word I/O port with TX and RX FIFOs
//
// Purpose: buffers CPU output-register writes toward the host (TX FIFO) and
// host-supplied words toward the CPU (RX FIFO), with sticky error flags.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cpu_out, cpu_out_wr         CPU write into the TX FIFO
//   cpu_in, cpu_in_valid        RX FIFO head word (0 when empty) and non-empty
//   cpu_in_ack                  CPU consumed the RX head word
//   host_tx_data/valid/ready    TX FIFO head toward the host, valid/ready
//   host_rx_data/valid/ready    host word into the RX FIFO, valid/ready
//   tx_count, rx_count          FIFO occupancy, 0..DEPTH
//   tx_overflow, rx_underflow   sticky error flags
//   flag_clr                    clears both sticky flags
module cpu_io_port #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] cpu_out,
  input  logic          cpu_out_wr,
  output logic [DW-1:0] cpu_in,
  output logic          cpu_in_valid,
  input  logic          cpu_in_ack,
  output logic [DW-1:0] host_tx_data,
  output logic          host_tx_valid,
  input  logic          host_tx_ready,
  input  logic [DW-1:0] host_rx_data,
  input  logic          host_rx_valid,
  output logic          host_rx_ready,
  output logic [AW:0]   tx_count,
  output logic [AW:0]   rx_count,
  output logic          tx_overflow,
  output logic          rx_underflow,
  input  logic          flag_clr
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] tx_mem [DEPTH];
  logic [DW-1:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_rd, tx_wr, rx_rd, rx_wr;

  logic tx_push, tx_pop, tx_drop;
  logic rx_push, rx_pop, rx_empty_ack;

  // Valid/ready are forced low in reset so the host sees no transfer while
  // the registered counts are still settling.
  assign host_tx_valid = !rst && (tx_count != '0);
  assign cpu_in_valid  = !rst && (rx_count != '0);
  assign host_rx_ready = !rst && (rx_count < FULL);

  // Show-ahead heads; zero when empty.
  assign host_tx_data = host_tx_valid ? tx_mem[tx_rd] : '0;
  assign cpu_in       = cpu_in_valid  ? rx_mem[rx_rd] : '0;

  assign tx_pop  = host_tx_valid && host_tx_ready;
  // A full TX FIFO still accepts a write when the host drains a word in the
  // same cycle.
  assign tx_push = cpu_out_wr && ((tx_count < FULL) || tx_pop);
  assign tx_drop = cpu_out_wr && !tx_push;

  assign rx_push      = host_rx_valid && host_rx_ready;
  assign rx_pop       = cpu_in_ack && (rx_count != '0);
  assign rx_empty_ack = cpu_in_ack && (rx_count == '0);

  // Storage carries no reset; pointers/counts alone define what is valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= cpu_out;
    if (rx_push) rx_mem[rx_wr] <= host_rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_rd        <= '0;
      tx_wr        <= '0;
      tx_count     <= '0;
      rx_rd        <= '0;
      rx_wr        <= '0;
      rx_count     <= '0;
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (tx_pop && !tx_push) tx_count <= tx_count - 1'b1;

      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (rx_pop && !rx_push) rx_count <= rx_count - 1'b1;

      // New error in the same cycle as a clear leaves the flag set.
      tx_overflow  <= (tx_overflow  && !flag_clr) || tx_drop;
      rx_underflow <= (rx_underflow && !flag_clr) || rx_empty_ack;
    end
  end

endmodule

// File: tb/tb_cpu_io_port.sv
// tb/tb_cpu_io_port.sv - directed vector bench for cpu_io_port
module tb_cpu_io_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_out = '0;
  logic        cpu_out_wr = 1'b0;
  logic [15:0] cpu_in;
  logic        cpu_in_valid;
  logic        cpu_in_ack = 1'b0;
  logic [15:0] host_tx_data;
  logic        host_tx_valid;
  logic        host_tx_ready = 1'b0;
  logic [15:0] host_rx_data = '0;
  logic        host_rx_valid = 1'b0;
  logic        host_rx_ready;
  logic [2:0]  tx_count, rx_count;
  logic        tx_overflow, rx_underflow;
  logic        flag_clr = 1'b0;

  always #5 clk = ~clk;

  cpu_io_port #(.DW(16), .DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_out(cpu_out), .cpu_out_wr(cpu_out_wr),
    .cpu_in(cpu_in), .cpu_in_valid(cpu_in_valid), .cpu_in_ack(cpu_in_ack),
    .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
    .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
    .tx_count(tx_count), .rx_count(rx_count),
    .tx_overflow(tx_overflow), .rx_underflow(rx_underflow),
    .flag_clr(flag_clr)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d] actual=0x%0h required=0x%0h", name, idx, act, exp);
    end
  endtask

  // Inputs applied before an edge; expected outputs sampled 1 time unit after it.
  typedef struct {
    logic rst, wr; logic [15:0] wd; logic ack, txr; logic [15:0] rd; logic rv, clr;
    logic tv; logic [15:0] td; logic [2:0] tc; logic ov;
    logic cv; logic [15:0] ci; logic [2:0] rc; logic rr, un;
  } vec_t;

  vec_t vq[$];

  initial begin
    int qsize;
    int exp_next;
    int sent;
    int cyc;
    int hdr[$];
    bit saw_full;
    bit do_push, do_pop;

    // rst wr wd ack txr rd rv clr | tv td tc ov | cv ci rc rr un
    vq.push_back('{1,0,16'h0000,0,0,16'h0000,0,0, 0,16'h0000,0,0, 0,16'h0000,0,0,0});
    vq.push_back('{1,0,16'h0000,0,0,16'h0000,0,0, 0,16'h0000,0,0, 0,16'h0000,0,0,0});
    vq.push_back('{0,0,16'h0000,0,0,16'h0000,0,0, 0,16'h0000,0,0, 0,16'h0000,0,1,0});
    // TX ordering and latency
    vq.push_back('{0,1,16'h1234,0,0,16'h0000,0,0, 1,16'h1234,1,0, 0,16'h0000,0,1,0});
    vq.push_back('{0,1,16'hBEEF,0,0,16'h0000,0,0, 1,16'h1234,2,0, 0,16'h0000,0,1,0});
    vq.push_back('{0,1,16'h0001,0,0,16'h0000,0,0, 1,16'h1234,3,0, 0,16'h0000,0,1,0});
    vq.push_back('{0,0,16'h0000,0,1,16'h0000,0,0, 1,16'hBEEF,2,0, 0,16'h0000,0,1,0});
    vq.push_back('{0,0,16'h0000,0,1,16'h0000,0,0, 1,16'h0001,1,0, 0,16'h0000,0,1,0});
    vq.push_back('{0,0,16'h0000,0,1,16'h0000,0,0, 0,16'h0000,0,0, 0,16'h0000,0,1,0});
    // TX overflow and flag clear
    vq.push_back('{0,1,16'h000A,0,0,16'h0000,0,0, 1,16'h000A,1,0, 0,16'h0000,0,1,0});
    vq.push_back('{0,1,16'h000B,0,0,16'h0000,0,0, 1,16'h000A,2,0, 0,16'h0000,0,1,0});
    vq.push_back('{0,1,16'h000C,0,0,16'h0000,0,0, 1,16'h000A,3,0, 0,16'h0000,0,1,0});
    vq.push_back('{0,1,16'h000D,0,0,16'h0000,0,0, 1,16'h000A,4,0, 0,16'h0000,0,1,0});
    vq.push_back('{0,1,16'h000E,0,0,16'h0000,0,0, 1,16'h000A,4,1, 0,16'h0000,0,1,0});
    vq.push_back('{0,0,16'h0000,0,0,16'h0000,0,1, 1,16'h000A,4,0, 0,16'h0000,0,1,0});
    // Full TX with simultaneous push and pop, then drain
    vq.push_back('{0,1,16'h00AA,0,1,16'h0000,0,0, 1,16'h000B,4,0, 0,16'h0000,0,1,0});
    vq.push_back('{0,0,16'h0000,0,1,16'h0000,0,0, 1,16'h000C,3,0, 0,16'h0000,0,1,0});
    vq.push_back('{0,0,16'h0000,0,1,16'h0000,0,0, 1,16'h000D,2,0, 0,16'h0000,0,1,0});
    vq.push_back('{0,0,16'h0000,0,1,16'h0000,0,0, 1,16'h00AA,1,0, 0,16'h0000,0,1,0});
    vq.push_back('{0,0,16'h0000,0,1,16'h0000,0,0, 0,16'h0000,0,0, 0,16'h0000,0,1,0});
    // RX path and underflow, set-wins on clear
    vq.push_back('{0,0,16'h0000,0,0,16'h5A5A,1,0, 0,16'h0000,0,0, 1,16'h5A5A,1,1,0});
    vq.push_back('{0,0,16'h0000,1,0,16'h0000,0,0, 0,16'h0000,0,0, 0,16'h0000,0,1,0});
    vq.push_back('{0,0,16'h0000,1,0,16'h0000,0,0, 0,16'h0000,0,0, 0,16'h0000,0,1,1});
    vq.push_back('{0,0,16'h0000,1,0,16'h0000,0,1, 0,16'h0000,0,0, 0,16'h0000,0,1,1});
    vq.push_back('{0,0,16'h0000,0,0,16'h0000,0,1, 0,16'h0000,0,0, 0,16'h0000,0,1,0});
    // Push plus ack on empty RX: no bypass, ack counts as underflow
    vq.push_back('{0,0,16'h0000,1,0,16'h1111,1,0, 0,16'h0000,0,0, 1,16'h1111,1,1,1});
    vq.push_back('{0,0,16'h0000,1,0,16'h0000,0,1, 0,16'h0000,0,0, 0,16'h0000,0,1,0});
    // Reset mid-transfer discards everything
    vq.push_back('{0,1,16'h7777,0,0,16'h8888,1,0, 1,16'h7777,1,0, 1,16'h8888,1,1,0});
    vq.push_back('{1,0,16'h0000,0,0,16'h0000,0,0, 0,16'h0000,0,0, 0,16'h0000,0,0,0});
    vq.push_back('{0,0,16'h0000,0,0,16'h0000,0,0, 0,16'h0000,0,0, 0,16'h0000,0,1,0});

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; cpu_out_wr = vq[i].wr; cpu_out = vq[i].wd;
      cpu_in_ack = vq[i].ack; host_tx_ready = vq[i].txr;
      host_rx_data = vq[i].rd; host_rx_valid = vq[i].rv; flag_clr = vq[i].clr;
      @(posedge clk); #1;
      chk("host_tx_valid", i, 32'(host_tx_valid), 32'(vq[i].tv));
      chk("host_tx_data",  i, 32'(host_tx_data),  32'(vq[i].td));
      chk("tx_count",      i, 32'(tx_count),      32'(vq[i].tc));
      chk("tx_overflow",   i, 32'(tx_overflow),   32'(vq[i].ov));
      chk("cpu_in_valid",  i, 32'(cpu_in_valid),  32'(vq[i].cv));
      chk("cpu_in",        i, 32'(cpu_in),        32'(vq[i].ci));
      chk("rx_count",      i, 32'(rx_count),      32'(vq[i].rc));
      chk("host_rx_ready", i, 32'(host_rx_ready), 32'(vq[i].rr));
      chk("rx_underflow",  i, 32'(rx_underflow),  32'(vq[i].un));
    end

    // RX backpressure and wrap: stream 0..9, ack held off first to fill the FIFO.
    rst = 0; cpu_out_wr = 0; host_tx_ready = 0; flag_clr = 0;
    qsize = 0; exp_next = 0; sent = 0; saw_full = 0;
    for (cyc = 0; cyc < 80 && exp_next < 10; cyc++) begin
      host_rx_valid = (sent < 10);
      host_rx_data  = 16'(sent);
      cpu_in_ack    = (cyc >= 6) && ($urandom_range(0, 2) != 0);
      chk("bp_ready", cyc, 32'(host_rx_ready), 32'(qsize < 4));
      if (qsize == 4) saw_full = 1;
      chk("bp_valid", cyc, 32'(cpu_in_valid), 32'(qsize != 0));
      do_push = host_rx_valid && (qsize < 4);
      do_pop  = cpu_in_ack && (qsize != 0);
      if (do_pop) begin
        chk("bp_order", cyc, 32'(cpu_in), 32'(exp_next));
        exp_next++;
        void'(hdr.pop_front());
      end
      if (do_push) begin
        hdr.push_back(sent);
        sent++;
      end
      qsize = hdr.size();
      @(posedge clk); #1;
      chk("bp_count", cyc, 32'(rx_count), 32'(qsize));
    end
    host_rx_valid = 0; cpu_in_ack = 0;
    chk("bp_received", 0, 32'(exp_next), 32'd10);
    chk("bp_saw_full", 0, 32'(saw_full), 32'd1);
    chk("bp_underflow", 0, 32'(rx_underflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
